note_arranger_poly: RTL
=======================

// Module: note_arranger_poly
// PURPOSE
//  Parametrised successor arranger: NUM_VOICES note_player slots instead of a fixed three.
//  Sits between song_reader and the note_player bank. Assigns incoming note words to free
//  voices, then on a rest/advance word loads all voices and gates advance_time for the rest
//  duration, counted in beat pulses.
//  Adds over the 3-voice version: sticky capture of voice_done pulses on any cycle, any
//  combination; a defined full-bank policy; and an overflow flag.
// PARAMETERS
//  NUM_VOICES     3  number of note_player slots, legal range 1..8.
//  STEAL_ON_FULL  0  full-bank policy. 0: drop the note and set overflow. 1: overwrite voice NUM_VOICES-1.
// PORTS
//  clk             in   1      system clock; the only clock in the block.
//  reset           in   1      asynchronous, active-low reset.
//  beat            in   1      one-cycle pulse from beat generator, one per 48th note.
//  note_to_load    in   16     song_reader word.
//                              [15]=1: rest word, [8:3] = rest duration.
//                              [15]=0: note word, [14:9] note, [8:3] duration, [2:1] stereo.
//  load_new_note   in   1      qualifies note_to_load for one cycle.
//  play_enable     in   1      level; low pauses playback.
//  voice_done      in   NV     per-voice one-cycle pulses from the note_players.
//  voice_load      out  NV     one-cycle load strobe to each note_player.
//  voice_note      out  6*NV   voice i occupies bits [6i+5:6i].
//  voice_duration  out  6*NV   voice i occupies bits [6i+5:6i].
//  voice_stereo    out  2*NV   voice i occupies bits [2i+1:2i].
//  voices_full     out  NV     occupancy vector; bit i = voice i holds a note.
//  note_done       out  1      registered one-cycle pulse to song_reader requesting the next word.
//  advance_time    out  1      high while note_players should advance.
//  overflow        out  1      sticky; cleared only by reset.
// BEHAVIOUR
//  Reset (async, active-low): state=ASSIGN. Clears count, voices_full, done_seen and all voice fields.
//    All outputs go to 0. Reset may assert mid-rest; the block restarts clean.
//  done capture: voice_done is registered once (done_q).
//    Then done_seen |= done_q on every cycle, in every state except LISTEN.
//  ASSIGN: waits for load_new_note.
//   - Note word, free voice exists: load the lowest-index free voice i.
//     Write note, duration and stereo to voice i, set voices_full[i], stay in ASSIGN.
//     note_done pulses on the next cycle.
//   - Note word, bank full: depends on STEAL_ON_FULL.
//     STEAL_ON_FULL=0: word discarded, overflow<=1, note_done still pulses.
//     STEAL_ON_FULL=1: overwrite voice NUM_VOICES-1, note_done pulses, overflow not set.
//   - Rest word, duration D: every voice with voices_full=0 gets note=0, duration=D, stereo=2'b11.
//     count <= D-1 (D=0 treated as 1, so count=0). Go to LOAD. No note_done.
//  LOAD: voice_load = all ones for exactly 1 cycle, then go to ADVANCE.
//  ADVANCE: advance_time=1. Priority order:
//   - beat && count==0: go to LISTEN; note_done pulses the next cycle.
//   - !play_enable: go to PAUSE; advance_time=0 in this cycle.
//   - beat: count--.
//  PAUSE: advance_time=0, count held, go to ADVANCE when play_enable=1.
//  LISTEN (1 cycle): voices_full &= ~(done_seen | done_q); done_seen<=0; go to ASSIGN.
//  Latency: note word accepted -> note_done 1 cycle.
//    Rest word -> voice_load 1 cycle -> advance_time 2 cycles.
//  load_new_note outside ASSIGN is ignored; song_reader must not issue it there.
//  Widths: count is 6-bit and never wraps (decrement only when count!=0).
// STRUCTURE
//  Shared package/header: state encodings ASSIGN/LOAD/ADVANCE/PAUSE/LISTEN; word field positions
//    (REST_BIT=15, NOTE_MSB/LSB, DUR_MSB/LSB, STEREO_MSB/LSB); REST_STEREO=2'b11.
//  One sub-module, voice_slot: per-voice note/duration/stereo/full registers with write and clear
//    ports, instantiated NUM_VOICES times through generate.
//  Free-voice pick is a priority encoder in the top module.
// TESTING
//  1. NV=3: three note words, then rest D=4.
//     -> voices 0,1,2 loaded in order; 3 note_done pulses.
//     -> voice_load=3'b111 once; advance_time high across 4 beats.
//     -> note_done 1 cycle after the 4th beat.
//  2. NV=3: one note, then rest D=2.
//     -> voices 1,2 get note=0, dur=2, stereo=11; voice 0 is unchanged.
//  3. NV=3, STEAL=0: 4th note word with bank full -> overflow=1, note_done pulses, fields unchanged.
//     STEAL=1: same stimulus -> voice 2 is overwritten.
//  4. voice_done[0] during ADVANCE and voice_done[2] while in PAUSE.
//     -> after LISTEN, voices_full=3'b010.
//  5. play_enable low after 1 beat of a D=3 rest.
//     -> advance_time=0, count held; resumes and ends after 2 more beats.
//  6. reset low mid-ADVANCE (asynchronous, off-edge).
//     -> all outputs 0 immediately; after release, state=ASSIGN and voices_full=0.

Source files
------------

// File: rtl/note_arranger_poly_pkg.sv
// note_arranger_poly_pkg: shared state encodings, song word field positions and voice record.
package note_arranger_poly_pkg;
    typedef enum logic [2:0] {ASSIGN, LOAD, ADVANCE, PAUSE, LISTEN} state_e;
    localparam int REST_BIT   = 15;
    localparam int NOTE_MSB   = 14;
    localparam int NOTE_LSB   = 9;
    localparam int DUR_MSB    = 8;
    localparam int DUR_LSB    = 3;
    localparam int STEREO_MSB = 2;
    localparam int STEREO_LSB = 1;
    localparam logic [1:0] REST_STEREO = 2'b11;
    typedef struct packed {
        logic [5:0] note;
        logic [5:0] dur;
        logic [1:0] stereo;
    } voice_t;
    // A zero-length rest still lasts one beat.
    function automatic logic [5:0] rest_count(input logic [5:0] d);
        return (d == 6'd0) ? 6'd0 : d - 6'd1;
    endfunction
endpackage

// File: rtl/note_arranger_poly_voice_slot.sv
// note_arranger_poly_voice_slot: one voice's note/duration/stereo fields plus its occupancy bit.
module note_arranger_poly_voice_slot
    import note_arranger_poly_pkg::*;
(
    input  logic   clk_i,
    input  logic   rst_ni,
    input  logic   wr_i,
    input  logic   set_full_i,
    input  logic   clr_full_i,
    input  voice_t data_i,
    output voice_t data_o,
    output logic   full_o
);
    voice_t data_q, data_d;
    logic   full_q, full_d;
    always_comb begin
        data_d = wr_i ? data_i : data_q;
        full_d = set_full_i ? 1'b1 : clr_full_i ? 1'b0 : full_q;
    end
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            data_q <= '0;
            full_q <= 1'b0;
        end else begin
            data_q <= data_d;
            full_q <= full_d;
        end
    end
    assign data_o = data_q;
    assign full_o = full_q;
endmodule

// File: rtl/note_arranger_poly.sv
// note_arranger_poly: assigns song words to NUM_VOICES note_player slots and gates
// advance_time for each rest, counted in beats.
module note_arranger_poly
    import note_arranger_poly_pkg::*;
#(
    parameter int NUM_VOICES    = 3,
    parameter bit STEAL_ON_FULL = 1'b0
) (
    input  logic                    clk_i,
    input  logic                    reset_ni,
    input  logic                    beat_i,
    input  logic [15:0]             note_to_load_i,
    input  logic                    load_new_note_i,
    input  logic                    play_enable_i,
    input  logic [NUM_VOICES-1:0]   voice_done_i,
    output logic [NUM_VOICES-1:0]   voice_load_o,
    output logic [6*NUM_VOICES-1:0] voice_note_o,
    output logic [6*NUM_VOICES-1:0] voice_duration_o,
    output logic [2*NUM_VOICES-1:0] voice_stereo_o,
    output logic [NUM_VOICES-1:0]   voices_full_o,
    output logic                    note_done_o,
    output logic                    advance_time_o,
    output logic                    overflow_o
);
    localparam int NV = NUM_VOICES;
    localparam int IW = (NV > 1) ? $clog2(NV) : 1;

    state_e        state_q;
    logic [5:0]    count_q;
    logic [NV-1:0] done_q, done_seen_q, voice_load_q;
    logic          note_done_q, overflow_q;
    logic [NV-1:0] full, wr, set_full, clr_full;
    logic          accept, is_rest, has_free, unused_bit;
    logic [IW-1:0] free_idx;
    voice_t        note_v, rest_v, wdata;
    voice_t        slot_q [NV];

    assign unused_bit = note_to_load_i[0];
    assign accept  = (state_q == ASSIGN) && load_new_note_i;
    assign is_rest = note_to_load_i[REST_BIT];
    assign note_v  = '{note:   note_to_load_i[NOTE_MSB:NOTE_LSB],
                       dur:    note_to_load_i[DUR_MSB:DUR_LSB],
                       stereo: note_to_load_i[STEREO_MSB:STEREO_LSB]};
    assign rest_v  = '{note: 6'd0, dur: note_to_load_i[DUR_MSB:DUR_LSB], stereo: REST_STEREO};

    always_comb begin
        has_free = 1'b0;
        free_idx = '0;
        for (int i = NV - 1; i >= 0; i--) begin
            if (!full[i]) begin
                has_free = 1'b1;
                free_idx = IW'(i);
            end
        end
    end

    // Rests fill every idle voice; a note takes the lowest free slot or, when stealing, the top one.
    always_comb begin
        wr       = '0;
        set_full = '0;
        wdata    = (accept && is_rest) ? rest_v : note_v;
        if (accept && is_rest) begin
            wr = ~full;
        end else if (accept && has_free) begin
            wr[free_idx]       = 1'b1;
            set_full[free_idx] = 1'b1;
        end else if (accept && STEAL_ON_FULL) begin
            wr[NV-1] = 1'b1;
        end
        clr_full = (state_q == LISTEN) ? (done_seen_q | done_q) : '0;
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q      <= ASSIGN;
            count_q      <= 6'd0;
            done_q       <= '0;
            done_seen_q  <= '0;
            voice_load_q <= '0;
            note_done_q  <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            done_q       <= voice_done_i;
            done_seen_q  <= (state_q == LISTEN) ? '0 : (done_seen_q | done_q);
            voice_load_q <= '0;
            note_done_q  <= 1'b0;
            case (state_q)
                ASSIGN: begin
                    if (accept && is_rest) begin
                        count_q      <= rest_count(note_to_load_i[DUR_MSB:DUR_LSB]);
                        voice_load_q <= '1;
                        state_q      <= LOAD;
                    end else if (accept) begin
                        note_done_q <= 1'b1;
                        if (!has_free && !STEAL_ON_FULL) overflow_q <= 1'b1;
                    end
                end
                LOAD: state_q <= ADVANCE;
                ADVANCE: begin
                    if (beat_i && count_q == 6'd0) begin
                        state_q     <= LISTEN;
                        note_done_q <= 1'b1;
                    end else if (!play_enable_i) begin
                        state_q <= PAUSE;
                    end else if (beat_i) begin
                        count_q <= count_q - 6'd1;
                    end
                end
                PAUSE:   state_q <= play_enable_i ? ADVANCE : PAUSE;
                LISTEN:  state_q <= ASSIGN;
                default: state_q <= ASSIGN;
            endcase
        end
    end

    genvar v;
    for (v = 0; v < NV; v++) begin : g_slot
        note_arranger_poly_voice_slot u_slot (
            .clk_i      (clk_i),
            .rst_ni     (reset_ni),
            .wr_i       (wr[v]),
            .set_full_i (set_full[v]),
            .clr_full_i (clr_full[v]),
            .data_i     (wdata),
            .data_o     (slot_q[v]),
            .full_o     (full[v])
        );
        assign voice_note_o[6*v +: 6]     = slot_q[v].note;
        assign voice_duration_o[6*v +: 6] = slot_q[v].dur;
        assign voice_stereo_o[2*v +: 2]   = slot_q[v].stereo;
    end

    // The final beat keeps advance_time high even if play_enable drops in that same cycle.
    assign advance_time_o = (state_q == ADVANCE) && (play_enable_i || (beat_i && count_q == 6'd0));
    assign voice_load_o   = voice_load_q;
    assign voices_full_o  = full;
    assign note_done_o    = note_done_q;
    assign overflow_o     = overflow_q;
endmodule
